// File: rtl/pov_spi_receiver.sv
// SPI slave that captures a 74-bit point-of-view word and applies it to the
// player position / direction outputs only at frame boundaries.
module pov_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int INC_STEP    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_ss_n,
  input  logic        load_new,
  input  logic        inc_px,
  input  logic        inc_py,
  output logic [14:0] o_playerX,
  output logic [14:0] o_playerY,
  output logic [10:0] o_facingX,
  output logic [10:0] o_facingY,
  output logic [10:0] o_vplaneX,
  output logic [10:0] o_vplaneY,
  output logic        o_pending
);

  localparam int FRAME_BITS = 74;
  localparam logic [6:0] CNT_FRAME = 7'd74;
  localparam logic [6:0] CNT_SAT   = 7'd75;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_d;
  logic                   ss_d;

  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   sclk_rise;
  logic                   ss_rise;
  logic                   frame_valid;
  logic                   commit;

  logic [6:0]             bit_cnt;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [FRAME_BITS-1:0]  staging;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sclk_rise   = 1'b0;
    ss_rise     = 1'b0;
    frame_valid = 1'b0;
    commit      = 1'b0;
    sclk_rise   = sclk_s & ~sclk_d;
    ss_rise     = ss_s & ~ss_d;
    frame_valid = ss_rise && (bit_cnt == CNT_FRAME);
    commit      = load_new && o_pending;
  end

  // Slave select idles high, so its synchroniser and edge flop reset to 1
  // to avoid a spurious end-of-frame right after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_ss_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (ss_s) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
      bit_cnt   <= (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + 7'd1;
    end
  end

  // A commit and a new frame can coincide: the commit reads the old staging
  // value while staging takes the new word, and pending stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging   <= '0;
      o_pending <= 1'b0;
    end else begin
      if (frame_valid) begin
        staging   <= shift_reg;
        o_pending <= 1'b1;
      end else if (commit) begin
        o_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_playerX <= 15'h0600;
      o_playerY <= 15'h0A00;
      o_facingX <= 11'h000;
      o_facingY <= 11'h200;
      o_vplaneX <= 11'h700;
      o_vplaneY <= 11'h000;
    end else if (commit) begin
      o_playerX <= staging[73:59];
      o_playerY <= staging[58:44];
      o_facingX <= staging[43:33];
      o_facingY <= staging[32:22];
      o_vplaneX <= staging[21:11];
      o_vplaneY <= staging[10:0];
    end else if (load_new) begin
      if (inc_px) o_playerX <= o_playerX + 15'(INC_STEP);
      if (inc_py) o_playerY <= o_playerY + 15'(INC_STEP);
    end
  end

endmodule

// File: tb/tb_pov_spi_receiver.sv
// Bench for pov_spi_receiver: directed vector table, hand-written corner
// sequences, and randomized transfers checked against a transaction model.
module tb_pov_spi_receiver;

  localparam int SYNC = 2;
  localparam int STEP = 8;
  localparam int HALF = SYNC + 2;

  typedef struct packed {
    logic [14:0] px;
    logic [14:0] py;
    logic [10:0] fx;
    logic [10:0] fy;
    logic [10:0] vx;
    logic [10:0] vy;
  } pov_t;

  typedef struct {
    int   nbits;
    pov_t word;
    logic ipx;
    logic ipy;
    logic exp_pend;
    pov_t exp_out;
  } vec_t;

  localparam pov_t RESET_POV = {15'h0600, 15'h0A00, 11'h000, 11'h200, 11'h700, 11'h000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_sclk = 1'b0;
  logic        i_mosi = 1'b0;
  logic        i_ss_n = 1'b1;
  logic        load_new = 1'b0;
  logic        inc_px = 1'b0;
  logic        inc_py = 1'b0;
  logic [14:0] o_playerX, o_playerY;
  logic [10:0] o_facingX, o_facingY, o_vplaneX, o_vplaneY;
  logic        o_pending;

  int n_checks = 0;
  int n_fail = 0;

  // Transaction-level reference: visible outputs, staged word, pending flag.
  pov_t m_out;
  pov_t m_stage;
  logic m_pend;

  pov_spi_receiver #(.SYNC_STAGES(SYNC), .INC_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_ss_n(i_ss_n),
    .load_new(load_new), .inc_px(inc_px), .inc_py(inc_py),
    .o_playerX(o_playerX), .o_playerY(o_playerY),
    .o_facingX(o_facingX), .o_facingY(o_facingY),
    .o_vplaneX(o_vplaneX), .o_vplaneY(o_vplaneY),
    .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic pov_t dut_out();
    return {o_playerX, o_playerY, o_facingX, o_facingY, o_vplaneX, o_vplaneY};
  endfunction

  function automatic vec_t mk(input int n, input pov_t w, input logic ipx, input logic ipy,
                              input logic ep, input pov_t eo);
    vec_t v;
    v.nbits = n; v.word = w; v.ipx = ipx; v.ipy = ipy; v.exp_pend = ep; v.exp_out = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input pov_t eo, input logic ep);
    check({name, " outputs"}, dut_out(), eo);
    check({name, " pending"}, {73'b0, o_pending}, {73'b0, ep});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_out = RESET_POV; m_stage = '0; m_pend = 1'b0;
  endtask

  task automatic begin_xfer();
    @(negedge clk);
    i_sclk = 1'b0;
    i_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Sends bit positions first..last, where position i carries word bit 73-i;
  // positions past the word carry random filler.
  task automatic send_bits(input pov_t w, input int first, input int last);
    logic [73:0] v;
    v = w;
    for (int i = first; i <= last; i++) begin
      i_mosi = (i < 74) ? v[73-i] : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      i_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      i_sclk = 1'b0;
    end
  endtask

  // Raises ss_n; optionally pulses load_new in the cycle the DUT sees that edge.
  task automatic end_xfer(input bit coincide_load);
    repeat (HALF) @(negedge clk);
    i_ss_n = 1'b1;
    if (coincide_load) begin
      repeat (SYNC) @(negedge clk);
      load_new = 1'b1;
      @(negedge clk);
      load_new = 1'b0;
    end
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic xfer(input int n, input pov_t w);
    if (n > 0) begin
      begin_xfer();
      send_bits(w, 0, n - 1);
      end_xfer(1'b0);
    end
    if (n == 74) begin
      m_stage = w;
      m_pend  = 1'b1;
    end
  endtask

  task automatic pulse_load(input logic ipx, input logic ipy);
    @(negedge clk);
    load_new = 1'b1; inc_px = ipx; inc_py = ipy;
    @(negedge clk);
    load_new = 1'b0; inc_px = 1'b0; inc_py = 1'b0;
    if (m_pend) begin
      m_out  = m_stage;
      m_pend = 1'b0;
    end else begin
      if (ipx) m_out.px = 15'((int'(m_out.px) + STEP) % 32768);
      if (ipy) m_out.py = 15'((int'(m_out.py) + STEP) % 32768);
    end
  endtask

  initial begin
    vec_t vecs[6];
    pov_t w1, w2, w3, wa, wb, wc, prev, e4, e5;

    w1 = {15'h1234, 15'h0ABC, 11'h1FF, 11'h600, 11'h0AA, 11'h555};
    w2 = {15'h7ABC, 15'h1357, 11'h123, 11'h456, 11'h789, 11'h0F0};
    w3 = {15'h7FF8, 15'h0100, 11'h011, 11'h022, 11'h033, 11'h044};
    e4 = {15'h0000, 15'h0108, 11'h011, 11'h022, 11'h033, 11'h044};
    e5 = {15'h0008, 15'h0108, 11'h011, 11'h022, 11'h033, 11'h044};
    vecs[0] = mk(74, w1, 1'b0, 1'b0, 1'b1, w1);
    vecs[1] = mk(73, w2, 1'b0, 1'b0, 1'b0, w1);
    vecs[2] = mk(75, w2, 1'b0, 1'b0, 1'b0, w1);
    vecs[3] = mk(74, w3, 1'b0, 1'b0, 1'b1, w3);
    vecs[4] = mk(0,  w2, 1'b1, 1'b1, 1'b0, e4);
    vecs[5] = mk(0,  w2, 1'b1, 1'b0, 1'b0, e5);

    do_reset();
    repeat (10) @(negedge clk);
    check_state("reset idle", RESET_POV, 1'b0);

    prev = RESET_POV;
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].nbits, vecs[i].word);
      check_state($sformatf("vec%0d after xfer", i), prev, vecs[i].exp_pend);
      pulse_load(vecs[i].ipx, vecs[i].ipy);
      check_state($sformatf("vec%0d after load", i), vecs[i].exp_out, 1'b0);
      prev = vecs[i].exp_out;
    end
    m_out = prev; m_pend = 1'b0;

    // Latest word wins; a commit coinciding with a new frame uses the old word.
    wa = pov_t'({$urandom, $urandom, $urandom});
    wb = pov_t'({$urandom, $urandom, $urandom});
    wc = pov_t'({$urandom, $urandom, $urandom});
    xfer(74, wa);
    xfer(74, wb);
    check_state("overwrite pending", prev, 1'b1);
    begin_xfer();
    send_bits(wc, 0, 73);
    end_xfer(1'b1);
    check_state("coincide commit", wb, 1'b1);
    m_out = wb; m_stage = wc; m_pend = 1'b1;
    pulse_load(1'b1, 1'b1);
    check_state("coincide follow-up", wc, 1'b0);

    // Reset partway through a frame: the tail alone must not commit.
    begin_xfer();
    send_bits(w1, 0, 39);
    do_reset();
    send_bits(w1, 40, 73);
    end_xfer(1'b0);
    check_state("reset mid-xfer", RESET_POV, 1'b0);
    pulse_load(1'b0, 1'b0);
    check_state("reset mid-xfer load", RESET_POV, 1'b0);

    for (int it = 0; it < 14; it++) begin
      int k;
      k = $urandom_range(1, 2);
      for (int j = 0; j < k; j++) begin
        int sel, n;
        pov_t w;
        sel = $urandom_range(0, 5);
        n = (sel <= 2) ? 74 : (sel == 3) ? 73 : (sel == 4) ? 75 : $urandom_range(1, 80);
        w = pov_t'({$urandom, $urandom, $urandom});
        xfer(n, w);
        check_state($sformatf("rand%0d xfer%0d n=%0d", it, j, n), m_out, m_pend);
      end
      pulse_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_state($sformatf("rand%0d load", it), m_out, m_pend);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pov_spi_receiver.md
POV_SPI_RECEIVER -- requirements
Module: pov_spi_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of each SPI input synchroniser; legal values 2..3.
REQ-002 Parameter INC_STEP, default 8: LSB step added to playerX/playerY per frame in debug-increment mode.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_sclk  in  1  SPI clock, asynchronous to clk, mode 0 (sample on rising edge).
REQ-006 i_mosi  in  1  SPI data, MSB first.
REQ-007 i_ss_n  in  1  SPI slave select, active low, frames one transfer.
REQ-008 load_new  in  1  one-cycle pulse at frame boundary (end of vblank) authorising a POV update.
REQ-009 inc_px / inc_py  in  1 each  debug auto-increment enables for playerX / playerY.
REQ-010 o_playerX, o_playerY  out  15 each  unsigned Q6.9 player position.
REQ-011 o_facingX, o_facingY, o_vplaneX, o_vplaneY  out  11 each  signed Q2.9 direction / view-plane vectors.
REQ-012 o_pending  out  1  high while a complete, uncommitted POV word sits in staging.

Function
REQ-013 All three SPI inputs SHALL pass through SYNC_STAGES-deep synchronisers before use; edge detection uses one further registered copy.
REQ-014 Synchronised ss_n high SHALL hold the bit counter at 0; the shift register keeps its contents.
REQ-015 Each detected sclk rising edge while synchronised ss_n is low SHALL shift synchronised mosi into the LSB of a 74-bit shift register and increment the bit counter, saturating at 75.
REQ-016 Latency from i_sclk rising at the input pins to the shift-register update SHALL be SYNC_STAGES+1 clk cycles; the bench SHALL keep sclk high and low each for at least SYNC_STAGES+1 clk cycles.
REQ-017 Bit order, first bit received = bit 73: playerX[14:0], playerY[14:0], facingX[10:0], facingY[10:0], vplaneX[10:0], vplaneY[10:0].
REQ-018 On a detected ss_n rising edge with counter == 74 exactly, the shift register SHALL be copied to staging and o_pending set on the next cycle.
REQ-019 On a detected ss_n rising edge with counter != 74 (short or long transfer), the transfer SHALL be discarded; staging and o_pending are unchanged.
REQ-020 A valid transfer arriving while o_pending = 1 SHALL overwrite staging (latest wins); o_pending stays 1.
REQ-021 On load_new with o_pending = 1, all six outputs SHALL take staging values on the next cycle and o_pending SHALL clear.
REQ-022 On load_new with o_pending = 0, o_playerX SHALL add INC_STEP if inc_px = 1, and o_playerY SHALL add INC_STEP if inc_py = 1, both modulo 2^15 (wrap 0x7FF8+8 -> 0x0000); other outputs hold.
REQ-023 A committed POV update SHALL take precedence over increments in the same cycle; increments are not applied on top of it.
REQ-024 If load_new coincides with a valid ss_n rising edge, the commit SHALL use the old staging value; staging then takes the new word and o_pending remains 1.
REQ-025 Outputs SHALL change only on load_new cycles or reset; they are never modified mid-frame.

Reset
REQ-026 On reset, o_playerX = 15'h0600 (3.0), o_playerY = 15'h0A00 (5.0), o_facingX = 11'h000, o_facingY = 11'h200 (1.0), o_vplaneX = 11'h700 (-0.5), o_vplaneY = 11'h000, and o_pending = 0.
REQ-027 On reset, the bit counter, shift register, staging register and synchroniser and edge-detect flops SHALL clear to 0, except the ss_n synchroniser and edge flops, which clear to 1.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer; after reset, the remaining bits of that transfer SHALL NOT produce a commit, because the counter mismatches.

Verification
REQ-029 Reset, then hold inputs idle for 10 cycles -> outputs equal the REQ-026 values; o_pending = 0.
REQ-030 Send a 74-bit word with playerX = 0x1234, playerY = 0x0ABC, facingX = 0x1FF, facingY = 0x600, vplaneX = 0x0AA, vplaneY = 0x555, then raise ss_n -> o_pending = 1, outputs unchanged; after a load_new pulse, outputs equal the sent values and o_pending = 0.
REQ-031 Send a 73-bit transfer and a 75-bit transfer, each followed by load_new -> staging and outputs unchanged, o_pending = 0.
REQ-032 With o_playerX = 0x7FF8, inc_px = 1, inc_py = 1, o_pending = 0, pulse load_new -> o_playerX = 0x0000, o_playerY incremented by 8.
REQ-033 Send word A, then word B, then pulse load_new coincident with the ss_n rising edge of a third word C -> outputs = B, o_pending = 1; a further load_new -> outputs = C.
REQ-034 Assert reset after bit 40 of a transfer, then send the remaining 34 bits and raise ss_n -> no commit; outputs equal the REQ-026 values.
